// File: rtl/mul_pkg.sv
// Shared types and decode helpers for the RV32M multiply sequencer.
package mul_pkg;

  localparam int unsigned OPC_W = 3;

  // funct3[1:0] of the legal multiply encodings.
  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUSY  = 2'b01,
    DONE  = 2'b10,
    DRAIN = 2'b11
  } mul_state_e;

  // funct3 values 1xx are not multiplies.
  function automatic logic is_legal(input logic [OPC_W-1:0] f3);
    return !f3[2];
  endfunction

  // Every multiply except MUL returns the upper product word.
  function automatic logic is_hi(input mul_op_e op);
    return op != MUL;
  endfunction

  function automatic logic rs1_signed(input mul_op_e op);
    return (op == MULH) || (op == MULHSU);
  endfunction

  function automatic logic rs2_signed(input mul_op_e op);
    return op == MULH;
  endfunction

endpackage

// File: rtl/mul_fuse_cache.sv
// Last-result cache: extended operand tags plus the full product of the
// most recent completed multiply. MUL matches on the low operand bits only,
// because its low product word does not depend on the extension bit.
module mul_fuse_cache #(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fill,
  input  logic              inval,
  input  logic [XLEN:0]     fill_a,
  input  logic [XLEN:0]     fill_b,
  input  logic [2*XLEN-1:0] fill_prod,
  input  logic [XLEN:0]     req_a,
  input  logic [XLEN:0]     req_b,
  input  logic              lo_only,
  output logic              hit_c,
  output logic [2*XLEN-1:0] product
);

  localparam int unsigned EW = XLEN + 1;

  logic [EW-1:0] tag_a;
  logic [EW-1:0] tag_b;
  logic          valid;

  // Tag/product register; invalidation wins over a fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_a   <= '0;
      tag_b   <= '0;
      valid   <= 1'b0;
      product <= '0;
    end else if (inval) begin
      valid <= 1'b0;
    end else if (fill) begin
      tag_a   <= fill_a;
      tag_b   <= fill_b;
      valid   <= 1'b1;
      product <= fill_prod;
    end
  end

  // Tag compare, full width unless only the low word is wanted.
  always_comb begin
    hit_c = 1'b0;
    if (valid) begin
      if (lo_only) begin
        hit_c = (req_a[XLEN-1:0] == tag_a[XLEN-1:0]) &&
                (req_b[XLEN-1:0] == tag_b[XLEN-1:0]);
      end else begin
        hit_c = (req_a == tag_a) && (req_b == tag_b);
      end
    end
  end

endmodule

// File: rtl/mul_ctrl.sv
// Sequencer between the EX stage and the iterative multiplier.
// Latches extended operands, pulses start, stalls the pipeline until done,
// and returns the low or high product word with a one-cycle flagM.
// Optional: define MUL_FUSE_EN to reuse the last product for a request
// with matching operands (e.g. MULH followed by MUL).
module mul_ctrl
  import mul_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mul_use,
  input  logic [2:0]        mul_opcode,
  input  logic [XLEN-1:0]   operand1,
  input  logic [XLEN-1:0]   operand2,
  input  logic              flush,
  output logic              start,
  output logic [XLEN:0]     mul_a,
  output logic [XLEN:0]     mul_b,
  input  logic              done,
  input  logic [2*XLEN-1:0] mul_product,
  output logic              stall,
  output logic [XLEN-1:0]   result_m,
  output logic              flagM,
  output logic              timeout_err
);

  localparam int unsigned EW = XLEN + 1;
  localparam int unsigned PW = 2 * XLEN;
  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC);

  mul_state_e      state, state_n;
  mul_op_e         op_q, op_n, req_op;
  logic [CW-1:0]   cnt, cnt_n, cnt_inc;
  logic [EW-1:0]   ext_a, ext_b, a_n, b_n;
  logic [XLEN-1:0] res_n;
  logic            start_n, flag_n, terr_n;
  logic            req_c, tmo_c, hit_c;
  logic [PW-1:0]   cache_prod;

  // Low word for MUL, high word for the MULH family.
  function automatic logic [XLEN-1:0] pick(input logic [PW-1:0] p, input mul_op_e op);
    return is_hi(op) ? p[PW-1:XLEN] : p[XLEN-1:0];
  endfunction

  // Request decode and operand extension.
  always_comb begin
    req_op  = mul_op_e'(mul_opcode[1:0]);
    req_c   = mul_use && !flush && is_legal(mul_opcode);
    ext_a   = {rs1_signed(req_op) & operand1[XLEN-1], operand1};
    ext_b   = {rs2_signed(req_op) & operand2[XLEN-1], operand2};
    cnt_inc = cnt + CW'(1);
  end

  // Watchdog: fires only when nothing else ends the wait this cycle.
  always_comb begin
    tmo_c = 1'b0;
    case (state)
      BUSY:    tmo_c = !flush && !done && (cnt_inc >= CNT_MAX);
      DRAIN:   tmo_c = !done && (cnt_inc >= CNT_MAX);
      default: tmo_c = 1'b0;
    endcase
  end

  // Pipeline freeze while a request is being accepted or is in flight.
  assign stall = ((state == IDLE) && req_c) ||
                 (state == BUSY) ||
                 ((state == DRAIN) && mul_use);

`ifdef MUL_FUSE_EN
  logic fill_c;
  logic inval_c;

  assign fill_c  = (state == BUSY) && done && !flush;
  assign inval_c = tmo_c;

  mul_fuse_cache #(
    .XLEN (XLEN)
  ) u_cache (
    .clk       (clk),
    .rst       (rst),
    .fill      (fill_c),
    .inval     (inval_c),
    .fill_a    (mul_a),
    .fill_b    (mul_b),
    .fill_prod (mul_product),
    .req_a     (ext_a),
    .req_b     (ext_b),
    .lo_only   (req_op == MUL),
    .hit_c     (hit_c),
    .product   (cache_prod)
  );
`else
  assign hit_c      = 1'b0;
  assign cache_prod = '0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    op_n    = op_q;
    a_n     = mul_a;
    b_n     = mul_b;
    start_n = 1'b0;
    flag_n  = 1'b0;
    res_n   = result_m;
    terr_n  = timeout_err;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (req_c) begin
          op_n = req_op;
          if (hit_c) begin
            res_n   = pick(cache_prod, req_op);
            flag_n  = 1'b1;
            state_n = DONE;
          end else begin
            a_n     = ext_a;
            b_n     = ext_b;
            start_n = 1'b1;
            state_n = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_n = cnt_inc;
        if (flush) begin
          // A done in the flush cycle already drained the multiplier.
          state_n = done ? IDLE : DRAIN;
        end else if (done) begin
          res_n   = pick(mul_product, op_q);
          flag_n  = 1'b1;
          state_n = DONE;
        end else if (tmo_c) begin
          terr_n  = 1'b1;
          state_n = IDLE;
        end
      end
      DONE: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
      DRAIN: begin
        cnt_n = cnt_inc;
        if (done) begin
          state_n = IDLE;
        end else if (tmo_c) begin
          terr_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      op_q        <= MUL;
      mul_a       <= '0;
      mul_b       <= '0;
      start       <= 1'b0;
      flagM       <= 1'b0;
      result_m    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      op_q        <= op_n;
      mul_a       <= a_n;
      mul_b       <= b_n;
      start       <= start_n;
      flagM       <= flag_n;
      result_m    <= res_n;
      timeout_err <= terr_n;
    end
  end

endmodule

// File: tb/tb_mul_ctrl.sv
// Bench for mul_ctrl: behavioural N-cycle multiplier plus a result scoreboard.
module tb_mul_ctrl;

  localparam int unsigned XLEN = 32;
  localparam int unsigned TMO  = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              mul_use;
  logic [2:0]        mul_opcode;
  logic [XLEN-1:0]   operand1;
  logic [XLEN-1:0]   operand2;
  logic              flush;
  logic              start;
  logic [XLEN:0]     mul_a;
  logic [XLEN:0]     mul_b;
  logic              done;
  logic [2*XLEN-1:0] mul_product;
  logic              stall;
  logic [XLEN-1:0]   result_m;
  logic              flagM;
  logic              timeout_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] exp_q[$];

  // run_op observations
  int          r_stall, r_start, r_flag, r_start_cyc, r_flag_cyc;
  logic [31:0] r_res;
  logic [32:0] r_a, r_b;

  // Multiplier model
  int                mdl_lat = 4;
  bit                mdl_en  = 1'b1;
  int                rem     = 0;
  bit                stray   = 1'b0;
  logic [2*XLEN-1:0] mdl_prod = '0;

  mul_ctrl #(.XLEN(XLEN), .TIMEOUT_CYC(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .mul_use     (mul_use),
    .mul_opcode  (mul_opcode),
    .operand1    (operand1),
    .operand2    (operand2),
    .flush       (flush),
    .start       (start),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .done        (done),
    .mul_product (mul_product),
    .stall       (stall),
    .result_m    (result_m),
    .flagM       (flagM),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] prod_of(input logic [32:0] a, input logic [32:0] b);
    logic signed [65:0] sa, sb, p;
    sa = $signed({{33{a[32]}}, a});
    sb = $signed({{33{b[32]}}, b});
    p  = sa * sb;
    return p[63:0];
  endfunction

  // Start cycle counts as cycle 1 of mdl_lat; done on cycle mdl_lat.
  always @(posedge clk) begin
    if (start && mdl_en) begin
      rem      <= mdl_lat - 1;
      mdl_prod <= prod_of(mul_a, mul_b);
    end else if (rem != 0) begin
      rem <= rem - 1;
    end
  end

  assign done        = (rem == 1) || stray;
  assign mul_product = mdl_prod;

  // Reference RV32M result from the architectural definition.
  function automatic logic [31:0] exp_of(input logic [1:0] f, input logic [31:0] x, input logic [31:0] y);
    logic [63:0]        uu;
    logic signed [63:0] ss;
    logic signed [64:0] su;
    uu = {32'b0, x} * {32'b0, y};
    ss = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
    su = $signed({{33{x[31]}}, x}) * $signed({33'b0, y});
    case (f)
      2'd0:    return uu[31:0];
      2'd1:    return ss[63:32];
      2'd2:    return su[63:32];
      default: return uu[63:32];
    endcase
  endfunction

  // Hold one instruction in EX until the pipeline is released.
  task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y, input int lat);
    r_stall = 0; r_start = 0; r_flag = 0; r_res = 'x; r_a = 'x; r_b = 'x;
    r_start_cyc = -1; r_flag_cyc = -1;
    mdl_lat = lat;
    if (!op[2]) exp_q.push_back(exp_of(op[1:0], x, y));
    mul_use = 1'b1; mul_opcode = op; operand1 = x; operand2 = y;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (stall) r_stall++;
      if (start) begin r_start++; r_start_cyc = cyc; r_a = mul_a; r_b = mul_b; end
      if (flagM) begin r_flag++; r_res = result_m; r_flag_cyc = cyc; end
      if (!stall) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    mul_use = 1'b0;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (start) ok = 1'b1;
      @(posedge clk); #1;
      if (ok) break;
    end
  endtask

  task automatic apply_reset;
    rst = 1'b1; mul_use = 1'b0; flush = 1'b0; stray = 1'b0;
    mul_opcode = 3'b000; operand1 = '0; operand2 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset;
    apply_reset();
    @(negedge clk);
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL reset_start got %b exp 0", start); end
    checks++; if (flagM !== 1'b0) begin errors++; $display("FAIL reset_flagM got %b exp 0", flagM); end
    checks++; if (result_m !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp 0", result_m); end
    checks++; if (mul_a !== 33'h0 || mul_b !== 33'h0) begin errors++; $display("FAIL reset_operands got %h %h exp 0 0", mul_a, mul_b); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", timeout_err); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
    @(posedge clk); #1;
  endtask

  task automatic test_mul;
    logic [31:0] e;
    run_op(3'b000, 32'h00000007, 32'hFFFFFFFD, 32);
    checks++; if (r_start !== 1) begin errors++; $display("FAIL mul_start_count got %0d exp 1", r_start); end
    checks++; if (r_stall !== 33) begin errors++; $display("FAIL mul_stall_cycles got %0d exp 33", r_stall); end
    checks++; if (r_flag !== 1) begin errors++; $display("FAIL mul_flagM_count got %0d exp 1", r_flag); end
    e = exp_q.pop_front();
    checks++; if (r_res !== e || e !== 32'hFFFFFFEB) begin errors++; $display("FAIL mul_result got %h exp %h", r_res, 32'hFFFFFFEB); end
  endtask

  task automatic test_high_back_to_back;
    logic [31:0] e;
    int          f;
    run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 4);
    e = exp_q.pop_front();
    checks++; if (r_res !== e || e !== 32'hFFFFFFFE) begin errors++; $display("FAIL mulhu_result got %h exp %h", r_res, 32'hFFFFFFFE); end
    checks++; if (r_stall !== 5) begin errors++; $display("FAIL mulhu_stall got %0d exp 5", r_stall); end
    f = r_flag_cyc;
    run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 4);
    e = exp_q.pop_front();
    checks++; if (r_res !== e || e !== 32'h00000000) begin errors++; $display("FAIL mulh_result got %h exp %h", r_res, 32'h0); end
    checks++; if (r_start_cyc !== f + 2) begin errors++; $display("FAIL b2b_start_cycle got %0d exp %0d", r_start_cyc, f + 2); end
    checks++; if (r_a !== 33'h1FFFFFFFF || r_b !== 33'h1FFFFFFFF) begin errors++; $display("FAIL mulh_ext got %h %h exp 1ffffffff 1ffffffff", r_a, r_b); end
    f = r_flag_cyc;
    run_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 6);
    e = exp_q.pop_front();
    checks++; if (r_res !== e || e !== 32'hFFFFFFFF) begin errors++; $display("FAIL mulhsu_result got %h exp %h", r_res, 32'hFFFFFFFF); end
    checks++; if (r_a !== 33'h1FFFFFFFF || r_b !== 33'h0FFFFFFFF) begin errors++; $display("FAIL mulhsu_ext got %h %h exp 1ffffffff 0ffffffff", r_a, r_b); end
    checks++; if (r_start_cyc !== f + 2) begin errors++; $display("FAIL b2b2_start_cycle got %0d exp %0d", r_start_cyc, f + 2); end
  endtask

  task automatic test_illegal;
    logic [2:0] ops [2];
    ops[0] = 3'b100;
    ops[1] = 3'b111;
    for (int k = 0; k < 2; k++) begin
      run_op(ops[k], 32'h5, 32'h6, 4);
      checks++; if (r_stall !== 0 || r_start !== 0 || r_flag !== 0) begin
        errors++; $display("FAIL illegal_op%0d got stall=%0d start=%0d flag=%0d exp 0 0 0", k, r_stall, r_start, r_flag);
      end
    end
  endtask

  task automatic test_flush;
    bit          ok;
    int          gaps, early, done_cyc, st_cyc, got_flag;
    logic [31:0] got_res, e;
    gaps = 0; early = 0; done_cyc = -1; st_cyc = -1; got_flag = 0; got_res = 'x;
    mdl_lat = 20;
    mul_use = 1'b1; mul_opcode = 3'b000; operand1 = 32'h1234; operand2 = 32'h10;
    wait_start(ok);
    checks++; if (!ok) begin errors++; $display("FAIL flush_first_start got none exp pulse"); end
    repeat (4) begin @(posedge clk); #1; end
    flush = 1'b1; mul_use = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0; mul_use = 1'b1; operand1 = 32'h5; operand2 = 32'h6; mdl_lat = 3;
    exp_q.push_back(exp_of(2'd0, 32'h5, 32'h6));
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (flagM) early++;
      if (!stall) gaps++;
      if (done && done_cyc < 0) done_cyc = cyc;
      if (start) begin st_cyc = cyc; break; end
      @(posedge clk); #1;
    end
    checks++; if (early !== 0) begin errors++; $display("FAIL flush_no_flagM got %0d exp 0", early); end
    checks++; if (gaps !== 0) begin errors++; $display("FAIL flush_drain_stall gaps got %0d exp 0", gaps); end
    checks++; if (done_cyc < 0 || st_cyc !== done_cyc + 2) begin errors++; $display("FAIL flush_restart_cycle got %0d exp %0d", st_cyc, done_cyc + 2); end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (flagM) begin got_flag++; got_res = result_m; end
      if (!stall) break;
    end
    @(posedge clk); #1;
    mul_use = 1'b0;
    e = exp_q.pop_front();
    checks++; if (got_flag !== 1 || got_res !== e) begin errors++; $display("FAIL flush_next_result got flag=%0d %h exp 1 %h", got_flag, got_res, e); end
  endtask

  task automatic test_timeout;
    bit          ok;
    int          busy_stall, early_err, flags;
    logic [31:0] e;
    busy_stall = 0; early_err = 0; flags = 0;
    mdl_en = 1'b0;
    mul_use = 1'b1; mul_opcode = 3'b000; operand1 = 32'h9; operand2 = 32'h9;
    wait_start(ok);
    mul_use = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL timeout_start got none exp pulse"); end
    for (int k = 0; k < 63; k++) begin
      @(negedge clk);
      if (stall) busy_stall++;
      if (timeout_err) early_err++;
      if (flagM) flags++;
      @(posedge clk); #1;
    end
    checks++; if (busy_stall !== 63 || early_err !== 0 || flags !== 0) begin
      errors++; $display("FAIL timeout_busy got stall=%0d err=%0d flag=%0d exp 63 0 0", busy_stall, early_err, flags);
    end
    @(negedge clk);
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_err got %b exp 1", timeout_err); end
    checks++; if (stall !== 1'b0 || flagM !== 1'b0) begin errors++; $display("FAIL timeout_release got stall=%b flag=%b exp 0 0", stall, flagM); end
    @(posedge clk); #1;
    mdl_en = 1'b1;
    run_op(3'b000, 32'h3, 32'h4, 2);
    e = exp_q.pop_front();
    checks++; if (r_res !== e || r_flag !== 1) begin errors++; $display("FAIL after_timeout_result got %h exp %h", r_res, e); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky got %b exp 1", timeout_err); end
  endtask

  task automatic test_rst_mid;
    bit ok;
    int s_cnt, f_cnt, st_cnt;
    s_cnt = 0; f_cnt = 0; st_cnt = 0;
    mdl_lat = 20;
    mul_use = 1'b1; mul_opcode = 3'b011; operand1 = 32'hFFFFFFFF; operand2 = 32'h3;
    wait_start(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_mid_start got none exp pulse"); end
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1; mul_use = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (start !== 1'b0 || flagM !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL rst_mid_ctrl got start=%b flag=%b stall=%b exp 0 0 0", start, flagM, stall);
    end
    checks++; if (result_m !== 32'h0 || mul_a !== 33'h0 || mul_b !== 33'h0) begin
      errors++; $display("FAIL rst_mid_data got %h %h %h exp 0 0 0", result_m, mul_a, mul_b);
    end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_mid_timeout got %b exp 0", timeout_err); end
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      stray = (i == 3);
      @(negedge clk);
      if (stall) s_cnt++;
      if (flagM) f_cnt++;
      if (start) st_cnt++;
    end
    stray = 1'b0;
    checks++; if (s_cnt !== 0 || f_cnt !== 0 || st_cnt !== 0) begin
      errors++; $display("FAIL stray_done got stall=%0d flag=%0d start=%0d exp 0 0 0", s_cnt, f_cnt, st_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fuse;
    logic [31:0] e;
    apply_reset();
    @(posedge clk); #1;
    run_op(3'b001, 32'h80000000, 32'h00000002, 6);
    e = exp_q.pop_front();
    checks++; if (r_res !== e || e !== 32'hFFFFFFFF) begin errors++; $display("FAIL fuse_mulh_result got %h exp %h", r_res, 32'hFFFFFFFF); end
    checks++; if (r_start !== 1) begin errors++; $display("FAIL fuse_mulh_start got %0d exp 1", r_start); end
    for (int k = 0; k < 2; k++) begin
      run_op(3'b000, 32'h80000000, 32'h00000002, 6);
      e = exp_q.pop_front();
      checks++; if (r_res !== e || e !== 32'h00000000 || r_flag !== 1) begin
        errors++; $display("FAIL fuse_mul%0d_result got %h flag=%0d exp 00000000 1", k, r_res, r_flag);
      end
`ifdef MUL_FUSE_EN
      checks++; if (r_start !== 0 || r_stall !== 1) begin
        errors++; $display("FAIL fuse_mul%0d_hit got start=%0d stall=%0d exp 0 1", k, r_start, r_stall);
      end
`else
      checks++; if (r_start !== 1 || r_stall !== 7) begin
        errors++; $display("FAIL fuse_mul%0d_issue got start=%0d stall=%0d exp 1 7", k, r_start, r_stall);
      end
`endif
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mul();
    test_high_back_to_back();
    test_illegal();
    test_flush();
    test_timeout();
    test_rst_mid();
    test_fuse();
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
